// File: rtl/sa_pkg.sv
// Shared constants, state type and latency helper for the systolic array controller.
package sa_pkg;

  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 6;
  localparam int DW_DEF     = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int PE_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    WLOAD,
    STREAM,
    DRAIN
  } sa_state_e;

  // Cycles from an accepted vector to its last column leaving the array, deskew included.
  function automatic int sa_latency(input int rows, input int cols, input int pe_lat);
    return 1 + pe_lat * (rows + cols - 1);
  endfunction

  localparam int L_DEF = sa_latency(ROWS_DEF, COLS_DEF, PE_LAT_DEF);

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth single-lane delay line used for the ifmap row skew and the psum column deskew.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] pipe_q [DEPTH];
  logic [DW-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = d;
    for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  // NOTE: the stages are reset, not left as bare storage, so nothing stale reaches the array after rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary scheduler: loads one weight tile per job, skews ifmap rows in, deskews psum columns out.
// Optional perf counters (perf_busy_cyc, perf_bubble_cyc) are built when SA_CTRL_PERF_EN is defined.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int DW     = DW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_vec,
  output logic                      busy,
  output logic                      done,
  input  logic                      w_valid,
  input  logic [ROWS*COLS*DW-1:0]   w_data,
  output logic                      w_ready,
  input  logic                      in_valid,
  input  logic [ROWS*DW-1:0]        in_data,
  output logic                      in_ready,
  output logic                      arr_load_en,
  output logic [ROWS*COLS*DW-1:0]   arr_weights,
  output logic [ROWS*DW-1:0]        arr_ifmap_west,
  input  logic [COLS*DW-1:0]        arr_psum_south,
  output logic                      out_valid,
  output logic [COLS*DW-1:0]        out_data
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]          perf_busy_cyc,
  output logic [CNT_W-1:0]          perf_bubble_cyc
`endif
);

  localparam int L = sa_latency(ROWS, COLS, PE_LAT);

  sa_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          num_q, num_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ROWS*COLS*DW-1:0]   weights_q, weights_d;
  logic [ROWS*DW-1:0]        s0_q, s0_d;
  logic [L-1:0]              vld_q, vld_d;
  logic                      out_valid_q, out_valid_d;
  logic [COLS*DW-1:0]        out_data_q, out_data_d;
  logic                      done_q, done_d;
  logic                      accept;
  logic [COLS*DW-1:0]        psum_deskew;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    weights_d   = weights_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    w_ready     = 1'b0;
    in_ready    = 1'b0;
    arr_load_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_vec;
          cnt_d   = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          weights_d = w_data;
          state_d   = WLOAD;
        end
      end
      WLOAD: begin
        arr_load_en = 1'b1;
        state_d     = (num_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        in_ready = (cnt_q < num_q);
        accept   = in_valid & in_ready;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // done lands one cycle after the last out_valid, which is still in its output register here.
        if (vld_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle cycles push zeros with a 0 tag so the array keeps marching without a stall input.
    s0_d        = accept ? in_data : '0;
    vld_d       = {vld_q[L-2:0], accept};
    out_valid_d = vld_q[L-1];
    out_data_d  = vld_q[L-1] ? psum_deskew : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cnt_q       <= '0;
      weights_q   <= '0;
      s0_q        <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      weights_q   <= weights_d;
      s0_q        <= s0_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign arr_weights = weights_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign arr_ifmap_west[0 +: DW] = s0_q[0 +: DW];
    end else begin : g_delay
      sa_skew_line #(.DEPTH(i*PE_LAT), .DW(DW)) u_line (
        .clk (clk),
        .rst (rst),
        .d   (s0_q[i*DW +: DW]),
        .q   (arr_ifmap_west[i*DW +: DW])
      );
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    if (j == COLS-1) begin : g_direct
      assign psum_deskew[j*DW +: DW] = arr_psum_south[j*DW +: DW];
    end else begin : g_delay
      sa_skew_line #(.DEPTH((COLS-1-j)*PE_LAT), .DW(DW)) u_line (
        .clk (clk),
        .rst (rst),
        .d   (arr_psum_south[j*DW +: DW]),
        .q   (psum_deskew[j*DW +: DW])
      );
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_busy_q, perf_busy_d;
  logic [CNT_W-1:0] perf_bub_q, perf_bub_d;

  always_comb begin
    perf_busy_d = perf_busy_q;
    perf_bub_d  = perf_bub_q;
    if (state_q == IDLE && start) begin
      perf_busy_d = '0;
      perf_bub_d  = '0;
    end else begin
      if (busy && !(&perf_busy_q)) perf_busy_d = perf_busy_q + 1'b1;
      if (state_q == STREAM && in_ready && !in_valid && !(&perf_bub_q))
        perf_bub_d = perf_bub_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_q <= '0;
      perf_bub_q  <= '0;
    end else begin
      perf_busy_q <= perf_busy_d;
      perf_bub_q  <= perf_bub_d;
    end
  end

  assign perf_busy_cyc   = perf_busy_q;
  assign perf_bubble_cyc = perf_bub_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: a cycle-accurate 4x6 array stand-in, a job-level scoreboard, directed jobs.
module tb_systolic_array_ctrl;
  import sa_pkg::*;

  localparam int R   = 4;
  localparam int C   = 6;
  localparam int W   = 16;
  localparam int CW  = 16;
  localparam int LAT = 1 + (R + C - 1);

  localparam logic [R*W-1:0] V1 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
  localparam logic [R*W-1:0] V2 = {16'h4800, 16'h4600, 16'h4400, 16'h4000};
  localparam logic [R*W-1:0] V3 = {16'h4A00, 16'h4880, 16'h4600, 16'h4200};
  localparam logic [R*W-1:0] U1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [R*W-1:0] U2 = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
  localparam logic [R*W-1:0] U3 = {16'h0CCC, 16'h0BBB, 16'h0AAA, 16'h0999};
  localparam logic [R*W-1:0] U4 = {16'h3210, 16'h0F0F, 16'h0EEE, 16'h0DDD};

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [CW-1:0]      num_vec = '0;
  logic               busy, done, w_ready, in_ready, arr_load_en, out_valid;
  logic               w_valid = 1'b0;
  logic [R*C*W-1:0]   w_data = '0;
  logic               in_valid = 1'b0;
  logic [R*W-1:0]     in_data = '0;
  logic [R*C*W-1:0]   arr_weights;
  logic [R*W-1:0]     arr_ifmap_west;
  logic [C*W-1:0]     arr_psum_south;
  logic [C*W-1:0]     out_data;
`ifdef SA_CTRL_PERF_EN
  logic [CW-1:0]      perf_busy_cyc, perf_bubble_cyc;
`endif

  systolic_array_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vec        (num_vec),
    .busy           (busy),
    .done           (done),
    .w_valid        (w_valid),
    .w_data         (w_data),
    .w_ready        (w_ready),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .arr_load_en    (arr_load_en),
    .arr_weights    (arr_weights),
    .arr_ifmap_west (arr_ifmap_west),
    .arr_psum_south (arr_psum_south),
    .out_valid      (out_valid),
    .out_data       (out_data)
`ifdef SA_CTRL_PERF_EN
    ,
    .perf_busy_cyc   (perf_busy_cyc),
    .perf_bubble_cyc (perf_bubble_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tiles used here hold at most one 1.0 per column, so the FP16 column sum is the single product.
  function automatic logic [W-1:0] fp_mac(input logic [W-1:0] p, input logic [W-1:0] x,
                                          input logic [W-1:0] w);
    return p | ((w == 16'h3C00) ? x : '0);
  endfunction

  function automatic logic [C*W-1:0] model_mvm(input logic [R*W-1:0] x, input logic [R*C*W-1:0] t);
    logic [C*W-1:0] y = '0;
    for (int j = 0; j < C; j++)
      for (int i = 0; i < R; i++)
        y[j*W +: W] = fp_mac(y[j*W +: W], x[i*W +: W], t[(i*C+j)*W +: W]);
    return y;
  endfunction

  function automatic logic [R*C*W-1:0] tile_diag(input bit anti);
    logic [R*C*W-1:0] t = '0;
    for (int i = 0; i < R; i++) t[(i*C + (anti ? C-1-i : i))*W +: W] = 16'h3C00;
    return t;
  endfunction

  // Stand-in for the pe_fp16 grid: one register per PE on both the ifmap and psum paths.
  logic [W-1:0] pe_w [R][C];
  logic [W-1:0] pe_x [R][C];
  logic [W-1:0] pe_p [R][C];
  initial
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        pe_w[i][j] = '0; pe_x[i][j] = '0; pe_p[i][j] = '0;
      end

  always @(posedge clk) begin
    logic [W-1:0] x_in, p_in;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        x_in = (j == 0) ? arr_ifmap_west[i*W +: W] : pe_x[i][j-1];
        p_in = (i == 0) ? '0 : pe_p[i-1][j];
        pe_x[i][j] <= x_in;
        pe_p[i][j] <= fp_mac(p_in, x_in, pe_w[i][j]);
        if (arr_load_en) pe_w[i][j] <= arr_weights[(i*C+j)*W +: W];
      end
  end

  always_comb
    for (int j = 0; j < C; j++) arr_psum_south[j*W +: W] = pe_p[R-1][j];

  // Job-level scoreboard: expectations derived from cycle numbers of handshakes, not DUT state.
  typedef struct { int due; logic [C*W-1:0] data; } exp_t;
  exp_t             exp_q[$];
  bit               job_on = 0, w_seen = 0;
  int               start_cyc = 0, wl_cyc = 0, done_due = -1, acc_cnt = 0, outs_left = 0;
  logic [CW-1:0]    num_m = '0;
  logic [R*C*W-1:0] tile_m = '0;

  always @(negedge clk) begin
    bit e_wr, e_ld, e_ir, e_done, e_busy, e_ov;
    if (!rst) begin
      job_on = 0; w_seen = 0; done_due = -1; exp_q.delete();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_load_en", arr_load_en, 0);
      check("rst_weights", arr_weights, 0);
      check("rst_ifmap_west", arr_ifmap_west, 0);
    end else begin
      e_wr   = job_on && !w_seen && cyc > start_cyc;
      e_ld   = job_on && w_seen && cyc == wl_cyc;
      e_ir   = job_on && w_seen && cyc > wl_cyc && acc_cnt < int'(num_m);
      e_done = (cyc == done_due);
      e_busy = job_on && cyc > start_cyc && !e_done;
      e_ov   = exp_q.size() > 0 && exp_q[0].due == cyc;
      check("w_ready", w_ready, e_wr);
      check("arr_load_en", arr_load_en, e_ld);
      check("in_ready", in_ready, e_ir);
      check("done", done, e_done);
      check("busy", busy, e_busy);
      check("out_valid", out_valid, e_ov);
      if (e_ld) check("arr_weights", arr_weights, tile_m);
      if (e_ov) begin
        check("out_data", out_data, exp_q[0].data);
        void'(exp_q.pop_front());
        outs_left--;
        if (outs_left == 0) done_due = cyc + 1;
      end
      if (e_done) job_on = 0;
      if (e_wr && w_valid) begin
        w_seen = 1; wl_cyc = cyc + 1; tile_m = w_data;
        if (num_m == '0) done_due = cyc + 3;
      end
      if (e_ir && in_valid) begin
        acc_cnt++;
        exp_q.push_back('{due: cyc + LAT + 1, data: model_mvm(in_data, tile_m)});
      end
      if (!job_on && start) begin
        job_on = 1; start_cyc = cyc; num_m = num_vec; acc_cnt = 0;
        outs_left = int'(num_vec); w_seen = 0; done_due = -1;
      end
    end
  end

  // Recorder of DUT activity for the hand-computed per-job checks.
  int             ov_cnt, done_cnt, done_cyc, load_cnt, load_cyc, acc0;
  bit             inrdy_seen, acc_seen;
  int             ov_cyc [16];
  logic [C*W-1:0] ov_data [16];

  always @(negedge clk) if (rst) begin
    if (out_valid) begin
      if (ov_cnt < 16) begin ov_data[ov_cnt] = out_data; ov_cyc[ov_cnt] = cyc; end
      ov_cnt++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (arr_load_en) begin load_cnt++; load_cyc = cyc; end
    if (in_ready) inrdy_seen = 1;
    if (in_valid && in_ready && !acc_seen) begin acc_seen = 1; acc0 = cyc; end
  end

  task automatic clear_rec();
    ov_cnt = 0; done_cnt = 0; done_cyc = -1; load_cnt = 0; load_cyc = -1;
    acc0 = -1; inrdy_seen = 0; acc_seen = 0;
    for (int k = 0; k < 16; k++) begin ov_cyc[k] = -1; ov_data[k] = '0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [CW-1:0] n);
    start = 1'b1; num_vec = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_tile(input logic [R*C*W-1:0] t);
    bit got = 0;
    w_valid = 1'b1; w_data = t;
    for (int g = 0; g < 50 && !got; g++) begin
      @(negedge clk);
      got = w_ready;
      tick();
    end
    w_valid = 1'b0;
    if (!got) check("tile_handshake_timeout", 0, 1);
  endtask

  task automatic send_vecs(input int n, input bit toggle, input logic [R*W-1:0] v0,
                           input logic [R*W-1:0] v1, input logic [R*W-1:0] v2,
                           input logic [R*W-1:0] v3);
    logic [R*W-1:0] vs [4];
    int k = 0;
    vs[0] = v0; vs[1] = v1; vs[2] = v2; vs[3] = v3;
    for (int c = 0; c < 200 && k < n; c++) begin
      in_valid = toggle ? (c % 2 == 0) : 1'b1;
      in_data  = vs[k];
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    if (k < n) check("vector_handshake_timeout", k, n);
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (done_cnt == 0 && g < 300) begin tick(); g++; end
    if (done_cnt == 0) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Identity tile, three back-to-back vectors.
    clear_rec();
    start_job(16'd3);
    send_tile(tile_diag(0));
    send_vecs(3, 0, V1, V2, V3, '0);
    wait_done("j1");
    check("j1_ov_count", ov_cnt, 3);
    check("j1_first_latency", ov_cyc[0] - acc0, 11);
    check("j1_last_latency", ov_cyc[2] - acc0, 13);
    check("j1_done_gap", done_cyc - ov_cyc[2], 1);
    check("j1_out0", ov_data[0], {32'h0, V1});
    check("j1_out2", ov_data[2], {32'h0, V3});
`ifdef SA_CTRL_PERF_EN
    check("j1_perf_busy", perf_busy_cyc, 16);
    check("j1_perf_bubble", perf_bubble_cyc, 0);
`endif

    // Back-to-back job with an anti-diagonal tile and a 1,0,1,0 valid pattern.
    clear_rec();
    start_job(16'd4);
    send_tile(tile_diag(1));
    send_vecs(4, 1, U1, U2, U3, U4);
    wait_done("j2");
    check("j2_ov_count", ov_cnt, 4);
    check("j2_gap", ov_cyc[1] - ov_cyc[0], 2);
    check("j2_span", ov_cyc[3] - ov_cyc[0], 6);
    check("j2_out0", ov_data[0], {16'h1111, 16'h2222, 16'h3333, 16'h4444, 32'h0});
    check("j2_done_gap", done_cyc - ov_cyc[3], 1);
`ifdef SA_CTRL_PERF_EN
    check("j2_perf_busy", perf_busy_cyc, 21);
    check("j2_perf_bubble", perf_bubble_cyc, 4);
`endif

    // Empty job.
    tick();
    clear_rec();
    start_job(16'd0);
    send_tile(tile_diag(0));
    wait_done("j0");
    check("j0_load_count", load_cnt, 1);
    check("j0_done_after_wload", done_cyc - load_cyc, 2);
    check("j0_in_ready_seen", inrdy_seen, 0);
    check("j0_ov_count", ov_cnt, 0);

    // Weight stall in LOAD_W.
    tick();
    clear_rec();
    start_job(16'd2);
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      check("stall_w_ready", w_ready, 1);
      check("stall_load_en", arr_load_en, 0);
      tick();
    end
    begin
      int hs;
      w_valid = 1'b1; w_data = tile_diag(0);
      @(negedge clk);
      hs = cyc;
      tick();
      w_valid = 1'b0;
      @(negedge clk);
      check("stall_load_after_w", arr_load_en, 1);
      check("stall_load_cycle", cyc - hs, 1);
      tick();
    end
    send_vecs(2, 0, V2, V1, '0, '0);
    wait_done("js");
    check("js_ov_count", ov_cnt, 2);
    check("js_out0", ov_data[0], {32'h0, V2});

    // Reset in the middle of streaming.
    tick();
    clear_rec();
    start_job(16'd5);
    send_tile(tile_diag(0));
    in_valid = 1'b1; in_data = V3;
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_load_en", arr_load_en, 0);
    check("midrst_weights", arr_weights, 0);
    check("midrst_in_ready", in_ready, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_out", ov_cnt, 0);
    clear_rec();
    start_job(16'd1);
    send_tile(tile_diag(0));
    send_vecs(1, 0, V1, '0, '0, '0);
    wait_done("jr");
    check("jr_ov_count", ov_cnt, 1);
    check("jr_out0", ov_data[0], {32'h0, V1});

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
